// File: rtl/call_request_queue.sv
// Elevator call front-end: debounces cabin/hall buttons, validates hall calls, queues them for memory_manager.
// Optional feature: define CALL_DEDUP_EN to drop pending calls already present in the FIFO.

module crq_debounce #(
  parameter int DEB_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic rise
);
  localparam int CW = $clog2(DEB_CYCLES + 1);

  logic [1:0]    sync;
  logic          level, level_q;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      sync    <= {sync[0], din};
      level_q <= level;
      if (sync[1] == level)
        cnt <= '0;
      else if (cnt == CW'(DEB_CYCLES - 1)) begin
        level <= sync[1];
        cnt   <= '0;
      end else
        cnt <= cnt + 1'b1;
    end
  end

  assign rise = level & ~level_q;
endmodule

module call_request_queue #(
  parameter int DEB_CYCLES = 16,
  parameter int DEPTH      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [3:0]              btn_cabin,
  input  logic                    btn_hall,
  input  logic                    switch_u_d,
  input  logic [1:0]              switch_floor,
  output logic                    req_valid,
  output logic [1:0]              req_floor,
  output logic [1:0]              req_type,
  input  logic                    req_ack,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic                    call_err
);
  localparam int AW   = $clog2(DEPTH);
  localparam int NSRC = 5;
  localparam int HALL = 4;

  typedef struct packed {
    logic [1:0] floor;
    logic [1:0] rtype;
  } call_t;

  logic [NSRC-1:0] raw, rise, pend, dup, cand, set_mask, clr_mask;
  logic            hall_up, hall_bad;
  logic [1:0]      hall_floor;
  call_t [NSRC-1:0] src;
  call_t           mem [DEPTH];
  call_t           wr_data;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;
  logic [2:0]      sel;
  logic            found, full, push, pop;

  assign raw = {btn_hall, btn_cabin};

  for (genvar g = 0; g < NSRC; g++) begin : g_deb
    crq_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
      .clk  (clk),
      .reset(reset),
      .din  (raw[g]),
      .rise (rise[g])
    );
  end

  assign hall_bad = switch_u_d ? (switch_floor == 2'd3) : (switch_floor == 2'd0);

  always_comb begin
    for (int s = 0; s < 4; s++) src[s] = {2'(s), 2'b11};
    src[HALL] = {hall_floor, (hall_up ? 2'b01 : 2'b10)};
  end

`ifdef CALL_DEDUP_EN
  logic [DEPTH-1:0] occ;

  // Slot k is live when its distance from the read pointer is below the count.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) occ[k] = {1'b0, AW'(k) - rd_ptr} < count;
  end
`endif

  always_comb begin
    dup = '0;
`ifdef CALL_DEDUP_EN
    for (int s = 0; s < NSRC; s++)
      for (int k = 0; k < DEPTH; k++)
        if (pend[s] && occ[k] && (mem[k] == src[s])) dup[s] = 1'b1;
`endif
    cand  = pend & ~dup;
    sel   = '0;
    found = 1'b0;
    for (int s = NSRC - 1; s >= 0; s--)
      if (cand[s]) begin
        sel   = 3'(s);
        found = 1'b1;
      end
    pop      = req_ack && (count != '0);
    full     = count == (AW + 1)'(DEPTH);
    push     = found && (!full || pop);
    wr_data  = src[sel];
    clr_mask = dup;
    if (push) clr_mask[sel] = 1'b1;
    set_mask = {rise[HALL] && !hall_bad, rise[3:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend       <= '0;
      hall_up    <= 1'b0;
      hall_floor <= '0;
      call_err   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else begin
      // A fresh press wins over a same-cycle service of that source.
      pend     <= (pend & ~clr_mask) | set_mask;
      call_err <= rise[HALL] && hall_bad;
      if (rise[HALL] && !hall_bad) begin
        hall_up    <= switch_u_d;
        hall_floor <= switch_floor;
      end
      if (push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign req_valid              = count != '0;
  assign {req_floor, req_type}  = req_valid ? mem[rd_ptr] : call_t'('0);
  assign fifo_count             = count;
endmodule

// File: tb/tb_call_request_queue.sv
// Bench for call_request_queue: directed scenarios plus random presses/acks against a queue-level model.
module tb_call_request_queue;
  localparam int D     = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0, reset = 1'b1;
  logic [3:0] btn_cabin = '0;
  logic       btn_hall = 1'b0, switch_u_d = 1'b0, req_ack = 1'b0;
  logic [1:0] switch_floor = '0;
  logic       req_valid, call_err;
  logic [1:0] req_floor, req_type;
  logic [2:0] fifo_count;

  int total = 0, bad = 0, err_seen = 0, merr = 0;
  int mq[$];
  logic [4:0] mpend = '0;
  int mhall = 0;

  call_request_queue #(.DEB_CYCLES(D), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .btn_cabin(btn_cabin), .btn_hall(btn_hall),
    .switch_u_d(switch_u_d), .switch_floor(switch_floor), .req_valid(req_valid),
    .req_floor(req_floor), .req_type(req_type), .req_ack(req_ack),
    .fifo_count(fifo_count), .call_err(call_err)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (call_err) err_seen++;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Entry encoding in the model: floor*4 + type.
  function automatic int ent(input int s);
    return (s < 4) ? s * 4 + 3 : mhall;
  endfunction

  task automatic msettle();
    int s;
    for (int it = 0; it < 16; it++) begin
`ifdef CALL_DEDUP_EN
      for (int i = 0; i < 5; i++)
        if (mpend[i]) foreach (mq[j]) if (mq[j] == ent(i)) mpend[i] = 1'b0;
`endif
      s = -1;
      for (int i = 4; i >= 0; i--) if (mpend[i]) s = i;
      if (s < 0 || mq.size() >= DEPTH) break;
      mq.push_back(ent(s));
      mpend[s] = 1'b0;
    end
  endtask

  task automatic chk_head(input string tag);
    int f = 0, t = 0;
    if (mq.size() > 0) begin
      f = mq[0] / 4;
      t = mq[0] % 4;
    end
    chk({tag, ".cnt"},   fifo_count, mq.size());
    chk({tag, ".valid"}, req_valid,  mq.size() > 0);
    chk({tag, ".floor"}, req_floor,  f);
    chk({tag, ".type"},  req_type,   t);
  endtask

  task automatic press(input logic [3:0] cab, input logic hall, input logic up,
                       input logic [1:0] fl);
    btn_cabin = cab; btn_hall = hall; switch_u_d = up; switch_floor = fl;
    tick(D + 3);
    btn_cabin = '0; btn_hall = 1'b0;
    tick(12);
    for (int i = 0; i < 4; i++) if (cab[i]) mpend[i] = 1'b1;
    if (hall) begin
      if ((up && fl == 2'd3) || (!up && fl == 2'd0)) merr++;
      else begin
        mpend[4] = 1'b1;
        mhall = int'(fl) * 4 + (up ? 1 : 2);
      end
    end
    msettle();
  endtask

  task automatic ack_one(input string tag);
    chk_head(tag);
    req_ack = 1'b1; tick(1); req_ack = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
    msettle();
    tick(3);
    chk_head({tag, ".after"});
  endtask

  initial begin
    int e0;
    tick(2);
    chk("rst.valid", req_valid, 0);
    chk("rst.floor", req_floor, 0);
    chk("rst.type",  req_type,  0);
    chk("rst.cnt",   fifo_count, 0);
    chk("rst.err",   call_err,  0);
    reset = 1'b0;
    tick(1);

    // single press latency
    btn_cabin = 4'b0100;
    for (int k = 1; k <= D + 4; k++) begin
      tick(1);
      if (k == D + 3) chk("lat.pre", req_valid, 0);
    end
    chk("lat.valid", req_valid, 1);
    chk("lat.floor", req_floor, 2);
    chk("lat.type",  req_type,  3);
    tick(2); btn_cabin = '0; tick(12);
    mq.push_back(2 * 4 + 3);
    ack_one("single");

    // bounce
    for (int k = 0; k < 10; k++) begin
      btn_cabin[0] = ~btn_cabin[0];
      tick(2);
    end
    tick(20);
    chk("bounce.cnt",   fifo_count, 0);
    chk("bounce.valid", req_valid,  0);

    // hall validation
    e0 = err_seen;
    press(4'b0000, 1'b1, 1'b1, 2'd3);
    chk("hall.bad.err", err_seen - e0, 1);
    chk("hall.bad.cnt", fifo_count, 0);
    press(4'b0000, 1'b1, 1'b0, 2'd2);
    chk("hall.dn.floor", req_floor, 2);
    chk("hall.dn.type",  req_type,  2);
    ack_one("hall.dn");

    // priority and full
    btn_cabin = 4'hf; btn_hall = 1'b1; switch_u_d = 1'b1; switch_floor = 2'd1;
    tick(D + 4);
    chk("prio.c1", fifo_count, 1);
    chk("prio.h0", req_floor, 0);
    for (int k = 2; k <= 4; k++) begin
      tick(1);
      chk("prio.cn", fifo_count, k);
    end
    tick(3);
    chk("prio.hold", fifo_count, 4);
    btn_cabin = '0; btn_hall = 1'b0;
    tick(12);
    mpend = 5'h1f; mhall = 1 * 4 + 1;
    msettle();
    chk_head("full");
    req_ack = 1'b1; tick(1); req_ack = 1'b0;
    chk("full.ack.cnt",   fifo_count, 4);
    chk("full.ack.floor", req_floor, 1);
    void'(mq.pop_front());
    msettle();
    for (int k = 0; k < 4; k++) ack_one("full.drain");

    // dedup
    press(4'b0010, 1'b0, 1'b0, 2'd0);
    chk("dedup.first", fifo_count, 1);
    press(4'b0010, 1'b0, 1'b0, 2'd0);
`ifdef CALL_DEDUP_EN
    chk("dedup.cnt", fifo_count, 1);
`else
    chk("dedup.cnt", fifo_count, 2);
`endif
    for (int k = 0; k < 3; k++) ack_one("dedup.drain");

    // reset mid-queue
    press(4'b0111, 1'b0, 1'b0, 2'd0);
    chk("mid.cnt", fifo_count, 3);
    reset = 1'b1; #1;
    chk("mid.rst.valid", req_valid, 0);
    chk("mid.rst.floor", req_floor, 0);
    chk("mid.rst.type",  req_type,  0);
    chk("mid.rst.cnt",   fifo_count, 0);
    tick(1); reset = 1'b0;
    mq.delete(); mpend = '0; mhall = 0;
    tick(30);
    chk_head("mid.after");

    // random presses and acks
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 2) != 0)
        press(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      else
        ack_one("rnd.ack");
      chk_head("rnd");
      chk("rnd.err", err_seen, merr);
    end
    for (int k = 0; k < 10; k++) ack_one("rnd.drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/call_request_queue.md
# call_request_queue

Front-end for the elevator request path: it debounces the four cabin floor buttons and the hall-call button, and validates hall calls built from the direction and floor switches. Accepted calls go into a small FIFO. The FIFO head is presented to memory_manager through a valid/ack handshake, so no press is lost while the manager is busy. It sits between the raw board inputs and memory_manager, replacing the direct button-to-manager wiring.

## Interface
Parameters:
- DEB_CYCLES, 16: number of consecutive stable synchronized samples required before the debounced level changes (≥2).
- DEPTH, 4: number of FIFO entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-high reset.
- btn_cabin  input  4  raw cabin buttons; bit i means floor i.
- btn_hall  input  1  raw hall-call button.
- switch_u_d  input  1  hall direction: 1 = up, 0 = down.
- switch_floor  input  2  hall floor, as {MSB, LSB}.
- req_valid  output  1  FIFO is non-empty; the head entry is on req_floor/req_type.
- req_floor  output  2  floor of the head entry.
- req_type  output  2  type of the head entry: 01 = hall up, 10 = hall down, 11 = cabin. The value 00 is never produced.
- req_ack  input  1  consumer pops the head entry.
- fifo_count  output  clog2(DEPTH)+1  number of occupied entries.
- call_err  output  1  one-cycle pulse when an illegal hall call is dropped.

## Operation
- Input conditioning: each of the 5 buttons passes through a 2-flop synchronizer and then its own debounce counter.
  - The counter increments while the synced value differs from the debounced level.
  - It clears whenever the two agree.
  - When the counter reaches DEB_CYCLES, the debounced level takes the synced value and the counter clears.
- A debounced 0→1 edge sets that source's pending bit. Releasing a button has no effect.
- Switch capture: switch_u_d and switch_floor are sampled on the cycle btn_hall's debounced edge occurs. They are held with that source's pending bit.
- Illegal hall calls are dropped when set, with call_err pulsing on the same cycle and no pending bit set:
  - up at floor 3;
  - down at floor 0.
- Arbiter: each cycle, at most one pending bit is serviced, in fixed priority cabin0 > cabin1 > cabin2 > cabin3 > hall.
  - The serviced entry is written to the FIFO and its pending bit cleared.
  - If the FIFO is full and no pop occurs this cycle, nothing is serviced and all pending bits hold.
- FIFO: circular buffer with read and write pointers.
  - A push and a pop in the same cycle are both performed, including when the FIFO is full; the count is unchanged.
  - req_ack while req_valid=0 is ignored.
- req_floor and req_type come straight from the head entry's storage. Both read 0 when the FIFO is empty.

## Timing
- Reset values: req_valid=0, req_floor=0, req_type=0, fifo_count=0, call_err=0. All sync flops, debounced levels, counters, pending bits and pointers are also cleared.
- Reset mid-operation discards every queued and pending call immediately. A button held through reset release generates a new call once debounced.
- Latency: a button held high from cycle 0, with nothing else pending and the FIFO empty, gives req_valid=1 at cycle DEB_CYCLES+4, where it changes exactly.
  - sync: 2 cycles;
  - debounce: DEB_CYCLES cycles;
  - pending: 1 cycle;
  - enqueue: 1 cycle.
- Pop: req_ack sampled high with req_valid=1 advances the head. The new head, or req_valid=0, appears the next cycle.
- Simultaneous presses are enqueued on consecutive cycles in priority order.
- A glitch shorter than DEB_CYCLES synced cycles causes no call.

## Configuration
- CALL_DEDUP_EN, defined: a pending source whose (floor, type) equals any occupied FIFO entry has its pending bit cleared without a write. No call_err is raised. This is evaluated in the same cycle as arbitration.
- CALL_DEDUP_EN, undefined: every serviced pending bit is written, so duplicates are allowed.

## Test plan
- Single press: btn_cabin[2] held, DEB_CYCLES=4 → req_valid rises at cycle 8 with req_floor=2, req_type=11. After one req_ack, req_valid=0 and fifo_count=0.
- Bounce: btn_cabin[0] toggles every 2 cycles for 20 cycles, then stays low → no req_valid.
- Hall validation:
  - up at floor 3 → call_err pulses once, fifo_count stays 0;
  - down at floor 2 → entry {2, 10}.
- Priority and full, DEPTH=4, no acks:
  - btn_cabin 4'b1111 and btn_hall (up, floor 1) pressed together → entries 0, 1, 2, 3 on consecutive cycles; the hall call stays pending with fifo_count=4;
  - one req_ack → the hall entry {1, 01} is enqueued in the same cycle and fifo_count stays 4.
- Dedup: press btn_cabin[1] twice while the first entry is still queued:
  - with CALL_DEDUP_EN → fifo_count=1;
  - without → fifo_count=2.
- Reset mid-queue: 3 entries queued, reset asserted for 1 cycle → all outputs 0 immediately, and no stale entry appears afterwards.
